// File: rtl/keypad_sprite_mover.sv
// Keypad-driven sprite mover for a text-mode VGA character buffer.
// Each accepted key erases the current cell with a trail word, draws the sprite one cell over, then rate-limits.
module keypad_sprite_mover #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned START_COL  = 10,
    parameter int unsigned START_ROW  = 10,
    parameter logic [15:0] SPRITE_CHR = 16'h0e02,
    parameter logic [15:0] TRAIL_CHR  = 16'h0e01,
    parameter logic [31:0] MOVE_DELAY = 32'd100,
    parameter bit          WRAP       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       timer,
    input  logic [7:0]        keypad,
    output logic [ADDR_W-1:0] vga_addr,
    output logic              vga_we,
    output logic [15:0]       vga_data,
    output logic [6:0]        cur_col,
    output logic [6:0]        cur_row,
    output logic              busy
);

    localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
    localparam logic [6:0]        LAST_ROW   = 7'(ROWS - 1);
    localparam logic [6:0]        START_C    = 7'(START_COL);
    localparam logic [6:0]        START_R    = 7'(START_ROW);
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ROW * COLS + START_COL);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);

    typedef enum logic [2:0] {
        S_INIT,
        S_DRAW0,
        S_IDLE,
        S_CALC,
        S_ERASE,
        S_DRAW,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT,
        DIR_RIGHT,
        DIR_DOWN,
        DIR_UP
    } dir_t;

    state_t            state;
    dir_t              dir;
    dir_t              key_dir;
    logic              key_hit;
    logic [6:0]        next_col;
    logic [6:0]        next_row;
    logic [ADDR_W-1:0] next_addr;
    logic [6:0]        step_col;
    logic [6:0]        step_row;
    logic              step_blocked;
    logic [ADDR_W-1:0] step_addr;
    logic [31:0]       t0;
    logic [31:0]       elapsed;
    logic              unused_keys;

    assign unused_keys = ^keypad[7:4];

    // Lowest set key bit wins.
    always_comb begin
        key_hit = |keypad[3:0];
        key_dir = DIR_UP;
        if (keypad[0])      key_dir = DIR_LEFT;
        else if (keypad[1]) key_dir = DIR_RIGHT;
        else if (keypad[2]) key_dir = DIR_DOWN;
    end

    // Neighbour cell in the latched direction, with wrap or clamp at the edges.
    always_comb begin
        step_col     = cur_col;
        step_row     = cur_row;
        step_blocked = 1'b0;
        unique case (dir)
            DIR_LEFT: begin
                if (cur_col != 7'd0) step_col = cur_col - 7'd1;
                else if (WRAP)       step_col = LAST_COL;
                else                 step_blocked = 1'b1;
            end
            DIR_RIGHT: begin
                if (cur_col != LAST_COL) step_col = cur_col + 7'd1;
                else if (WRAP)           step_col = 7'd0;
                else                     step_blocked = 1'b1;
            end
            DIR_DOWN: begin
                if (cur_row != LAST_ROW) step_row = cur_row + 7'd1;
                else if (WRAP)           step_row = 7'd0;
                else                     step_blocked = 1'b1;
            end
            DIR_UP: begin
                if (cur_row != 7'd0) step_row = cur_row - 7'd1;
                else if (WRAP)       step_row = LAST_ROW;
                else                 step_blocked = 1'b1;
            end
            default: step_blocked = 1'b1;
        endcase
        step_addr = ADDR_W'(step_row) * COLS_A + ADDR_W'(step_col);
    end

    // Modular difference keeps the delay correct across timer wrap.
    assign elapsed = timer - t0;

    // Outputs are loaded on the edge entering the state that performs the write,
    // so each write pulse coincides with that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            dir       <= DIR_LEFT;
            vga_addr  <= '0;
            vga_we    <= 1'b0;
            vga_data  <= '0;
            cur_col   <= START_C;
            cur_row   <= START_R;
            next_col  <= START_C;
            next_row  <= START_R;
            next_addr <= '0;
            t0        <= '0;
            busy      <= 1'b1;
        end else begin
            vga_we   <= 1'b0;
            vga_data <= '0;
            busy     <= 1'b1;
            case (state)
                S_INIT: begin
                    vga_addr <= START_ADDR;
                    vga_we   <= 1'b1;
                    vga_data <= SPRITE_CHR;
                    state    <= S_DRAW0;
                end
                S_DRAW0: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (key_hit) begin
                        dir   <= key_dir;
                        state <= S_CALC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_CALC: begin
                    next_col  <= step_col;
                    next_row  <= step_row;
                    next_addr <= step_addr;
                    if (step_blocked) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        vga_we   <= 1'b1;
                        vga_data <= TRAIL_CHR;
                        state    <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    vga_addr <= next_addr;
                    cur_col  <= next_col;
                    cur_row  <= next_row;
                    vga_we   <= 1'b1;
                    vga_data <= SPRITE_CHR;
                    state    <= S_DRAW;
                end
                S_DRAW: begin
                    t0    <= timer;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (elapsed >= MOVE_DELAY) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_sprite_mover.sv
// Directed bench for keypad_sprite_mover: one wrapping mover at (10,10),
// one clamping mover at (79,0) and one wrapping mover at (0,0).
module tb_keypad_sprite_mover;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] timer = 32'd0;
    logic        tload = 1'b0;
    logic [31:0] tload_val = 32'd0;
    logic [7:0]  a_key = 8'd0, b_key = 8'd0, c_key = 8'd0;

    logic [11:0] a_addr, b_addr, c_addr;
    logic        a_we, b_we, c_we;
    logic [15:0] a_data, b_data, c_data;
    logic [6:0]  a_col, a_row, b_col, b_row, c_col, c_row;
    logic        a_busy, b_busy, c_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) timer <= tload ? tload_val : timer + 32'd1;

    keypad_sprite_mover dut_a (
        .clk(clk), .rst(rst), .timer(timer), .keypad(a_key),
        .vga_addr(a_addr), .vga_we(a_we), .vga_data(a_data),
        .cur_col(a_col), .cur_row(a_row), .busy(a_busy)
    );

    keypad_sprite_mover #(.START_COL(79), .START_ROW(0), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .timer(timer), .keypad(b_key),
        .vga_addr(b_addr), .vga_we(b_we), .vga_data(b_data),
        .cur_col(b_col), .cur_row(b_row), .busy(b_busy)
    );

    keypad_sprite_mover #(.START_COL(0), .START_ROW(0)) dut_c (
        .clk(clk), .rst(rst), .timer(timer), .keypad(c_key),
        .vga_addr(c_addr), .vga_we(c_we), .vga_data(c_data),
        .cur_col(c_col), .cur_row(c_row), .busy(c_busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until the chosen mover's busy drops, bounded at 300 cycles.
    task automatic wait_idle(input int which, output int n);
        logic b;
        n = 0;
        do begin
            tick();
            n++;
            case (which)
                0:       b = a_busy;
                1:       b = b_busy;
                default: b = c_busy;
            endcase
        end while (b && n < 300);
    endtask

    initial begin
        int n;
        int d1, d2, found;
        logic saw_we;
        logic [7:0] blocked_keys [2];

        blocked_keys[0] = 8'h02;
        blocked_keys[1] = 8'h08;

        repeat (3) tick();
        chk("rst_we",   32'(a_we),   32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_col",  32'(a_col),  32'd10);
        chk("rst_row",  32'(a_row),  32'd10);

        // Release: sprite drawn at start, busy drops two cycles later.
        rst = 1'b0;
        tick();
        chk("init_we",   32'(a_we),   32'd1);
        chk("init_addr", 32'(a_addr), 32'd810);
        chk("init_data", 32'(a_data), 32'h0e02);
        chk("init_busy", 32'(a_busy), 32'd1);
        chk("init_b_addr", 32'(b_addr), 32'd79);
        tick();
        chk("idle_we",   32'(a_we),   32'd0);
        chk("idle_data", 32'(a_data), 32'd0);
        chk("idle_busy", 32'(a_busy), 32'd0);

        // Single right press from (10,10).
        a_key = 8'h02;
        tick();
        a_key = 8'h00;
        chk("r_calc_we", 32'(a_we), 32'd0);
        tick();
        chk("r_erase_we",   32'(a_we),   32'd1);
        chk("r_erase_addr", 32'(a_addr), 32'd810);
        chk("r_erase_data", 32'(a_data), 32'h0e01);
        tick();
        chk("r_draw_we",   32'(a_we),   32'd1);
        chk("r_draw_addr", 32'(a_addr), 32'd811);
        chk("r_draw_data", 32'(a_data), 32'h0e02);
        chk("r_col",       32'(a_col),  32'd11);
        wait_idle(0, n);
        chk("r_wait_len", 32'(n), 32'd101);

        // Left and right held together: left wins and repeats every 104 cycles.
        a_key = 8'hF3;
        found = 0; d1 = 0; d2 = 0;
        for (int cyc = 1; cyc <= 400 && found < 2; cyc++) begin
            tick();
            if (a_we && a_data == 16'h0e02) begin
                found++;
                if (found == 1) begin
                    d1 = cyc;
                    chk("hold_col1", 32'(a_col), 32'd10);
                end else begin
                    d2 = cyc;
                    a_key = 8'h00;
                    chk("hold_col2", 32'(a_col), 32'd9);
                end
            end
        end
        a_key = 8'h00;
        chk("hold_draws",   32'(found),   32'd2);
        chk("hold_spacing", 32'(d2 - d1), 32'd104);
        wait_idle(0, n);
        chk("hold_wait_len", 32'(n), 32'd101);

        // Wrap from (0,0): up to row 29, then left to column 79.
        c_key = 8'h08;
        tick();
        c_key = 8'h00;
        tick();
        chk("up_erase_addr", 32'(c_addr), 32'd0);
        chk("up_erase_data", 32'(c_data), 32'h0e01);
        tick();
        chk("up_draw_addr", 32'(c_addr), 32'd2320);
        chk("up_draw_we",   32'(c_we),   32'd1);
        chk("up_row",       32'(c_row),  32'd29);
        chk("up_col",       32'(c_col),  32'd0);
        wait_idle(2, n);
        chk("up_wait_len", 32'(n), 32'd101);
        c_key = 8'h01;
        tick();
        c_key = 8'h00;
        tick();
        chk("lw_erase_addr", 32'(c_addr), 32'd2320);
        tick();
        chk("lw_draw_addr", 32'(c_addr), 32'd2399);
        chk("lw_col",       32'(c_col),  32'd79);
        chk("lw_row",       32'(c_row),  32'd29);

        // Clamp at (79,0): right and up are both blocked.
        foreach (blocked_keys[k]) begin
            b_key = blocked_keys[k];
            tick();
            b_key = 8'h00;
            chk("clamp_busy_hi", 32'(b_busy), 32'd1);
            saw_we = b_we;
            tick();
            chk("clamp_busy_lo", 32'(b_busy), 32'd0);
            saw_we = saw_we | b_we;
            repeat (8) begin
                tick();
                saw_we = saw_we | b_we;
            end
            chk("clamp_no_we", 32'(saw_we), 32'd0);
            chk("clamp_col",   32'(b_col),  32'd79);
            chk("clamp_row",   32'(b_row),  32'd0);
        end

        // Delay measured across timer wrap.
        tload_val = 32'hFFFF_FFF0;
        tload = 1'b1;
        tick();
        tload = 1'b0;
        a_key = 8'h02;
        tick();
        a_key = 8'h00;
        tick();
        tick();
        chk("tw_draw_addr", 32'(a_addr), 32'd810);
        chk("tw_draw_we",   32'(a_we),   32'd1);
        wait_idle(0, n);
        chk("tw_wait_len", 32'(n), 32'd101);

        // Reset asserted mid-erase.
        a_key = 8'h02;
        tick();
        a_key = 8'h00;
        tick();
        chk("ab_erase_we", 32'(a_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("ab_we",   32'(a_we),   32'd0);
        chk("ab_addr", 32'(a_addr), 32'd0);
        chk("ab_data", 32'(a_data), 32'd0);
        chk("ab_busy", 32'(a_busy), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("re_we",     32'(a_we),   32'd1);
        chk("re_addr",   32'(a_addr), 32'd810);
        chk("re_data",   32'(a_data), 32'h0e02);
        chk("re_col",    32'(a_col),  32'd10);
        chk("re_c_addr", 32'(c_addr), 32'd0);
        tick();
        chk("re_busy", 32'(a_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
